// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared types and helpers for the SPI command arbiter.
package spi_cmd_arbiter_pkg;

    // Transaction FSM: arbitrate, hand command to master, wait for busy, wait for done
    typedef enum logic [1:0] {
        StArb      = 2'd0,
        StIssue    = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } arb_state_e;

    // Width of the accept-to-completion timeout counter
    localparam int unsigned TimerWidth = 16;

    // MSB of a command selects write (1) or read (0)
    function automatic int unsigned cmd_wr_bit(input int unsigned cmd_width);
        return cmd_width - 1;
    endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr.sv
// Combinational round-robin grant: first set request strictly after ptr, wrapping.
module spi_cmd_arbiter_rr #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IdxW-1:0]    gnt_idx
);

    logic [IdxW-1:0] cand;

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last-served requester is checked last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            cand = IdxW'((int'(ptr) + off) % int'(NUM_REQ));
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI master command port among NUM_REQ requesters, one command in flight.
module spi_cmd_arbiter
    import spi_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CMD_WIDTH  = 12,
    parameter int unsigned READ_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 4096,
    localparam int unsigned IdxW      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic                         rsp_err,
    output logic [READ_WIDTH-1:0]        rsp_data,
    output logic [CMD_WIDTH-1:0]         m_cmd,
    output logic                         m_cmd_vld,
    input  logic                         m_cmd_rdy,
    input  logic                         m_read_vld,
    input  logic [READ_WIDTH-1:0]        m_read_data,
    output logic                         busy,
    output logic [IdxW-1:0]              grant_id
);

    localparam int unsigned           CmdWrBit = cmd_wr_bit(CMD_WIDTH);
    // Timer value seen on the cycle whose edge makes TIMEOUT cycles since accept
    localparam logic [TimerWidth-1:0] TmoLast  = TimerWidth'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        ptr_q;
    logic [IdxW-1:0]        grant_id_q;
    logic [CMD_WIDTH-1:0]   cmd_q;
    logic [NUM_REQ-1:0]     req_rdy_q;
    logic [NUM_REQ-1:0]     rsp_vld_q;
    logic                   rsp_err_q;
    logic [READ_WIDTH-1:0]  rsp_data_q;
    logic [TimerWidth-1:0]  tmr_q;

    logic                   arb_any;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IdxW-1:0]        arb_idx;
    logic                   is_wr, waiting, accept, done, tmo;

    spi_cmd_arbiter_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_vld),
        .ptr     (ptr_q),
        .any     (arb_any),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Transaction events; completion takes priority over a coincident timeout
    always_comb begin
        is_wr   = cmd_q[CmdWrBit];
        waiting = (state_q == StWaitBusy) || (state_q == StWaitDone);
        accept  = (state_q == StIssue) && m_cmd_rdy;
        done    = (state_q == StWaitDone) && (is_wr ? m_cmd_rdy : m_read_vld);
        tmo     = waiting && (tmr_q == TmoLast);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StArb;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:      if (arb_any) state_d = StIssue;
            StIssue:    if (accept) state_d = StWaitBusy;
            StWaitBusy: begin
                if (tmo) state_d = StArb;
                else if (!m_cmd_rdy) state_d = StWaitDone;
            end
            StWaitDone: if (done || tmo) state_d = StArb;
            default:    state_d = StArb;
        endcase
    end

    // FSM outputs: decoded straight from state so reset drops them asynchronously
    always_comb begin
        m_cmd_vld = (state_q == StIssue);
        busy      = (state_q != StArb);
    end

    // Grant capture, timeout counter and registered response pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IdxW'(NUM_REQ - 1);
            grant_id_q <= '0;
            cmd_q      <= '0;
            req_rdy_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            tmr_q      <= '0;
        end else begin
            req_rdy_q <= '0;
            rsp_vld_q <= '0;
            rsp_err_q <= 1'b0;
            if (state_q == StArb && arb_any) begin
                req_rdy_q  <= arb_gnt;
                cmd_q      <= req_cmd[arb_idx*CMD_WIDTH +: CMD_WIDTH];
                grant_id_q <= arb_idx;
                ptr_q      <= arb_idx;
            end
            if (accept) begin
                tmr_q <= '0;
            end else if (waiting) begin
                tmr_q <= tmr_q + 1'b1;
            end
            if (done) begin
                rsp_vld_q  <= NUM_REQ'(1) << grant_id_q;
                rsp_data_q <= is_wr ? '0 : m_read_data;
            end else if (tmo) begin
                rsp_vld_q  <= NUM_REQ'(1) << grant_id_q;
                rsp_err_q  <= 1'b1;
                rsp_data_q <= '0;
            end
        end
    end

    assign req_rdy  = req_rdy_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_data_q;
    assign m_cmd    = cmd_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter: expected grants and responses queued at stimulus time.
module tb_spi_cmd_arbiter;

    localparam int NumReq = 4;
    localparam int CmdW   = 12;
    localparam int RdW    = 8;
    localparam int Tmo    = 4096;

    typedef struct {
        int         id;
        bit         err;
        logic [7:0] data;
    } rsp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NumReq*CmdW-1:0]   req_cmd = '0;
    logic [NumReq-1:0]        req_vld = '0;
    logic [NumReq-1:0]        req_rdy;
    logic [NumReq-1:0]        rsp_vld;
    logic                     rsp_err;
    logic [RdW-1:0]           rsp_data;
    logic [CmdW-1:0]          m_cmd;
    logic                     m_cmd_vld;
    logic                     m_cmd_rdy = 1'b1;
    logic                     m_read_vld = 1'b0;
    logic [RdW-1:0]           m_read_data = '0;
    logic                     busy;
    logic [1:0]               grant_id;

    rsp_t        exp_rsp[$];
    int          exp_gnt[$];
    logic [11:0] cmds[NumReq];
    int          total = 0;
    int          bad = 0;

    spi_cmd_arbiter #(
        .NUM_REQ    (NumReq),
        .CMD_WIDTH  (CmdW),
        .READ_WIDTH (RdW),
        .TIMEOUT    (Tmo)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_cmd     (req_cmd),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_err     (rsp_err),
        .rsp_data    (rsp_data),
        .m_cmd       (m_cmd),
        .m_cmd_vld   (m_cmd_vld),
        .m_cmd_rdy   (m_cmd_rdy),
        .m_read_vld  (m_read_vld),
        .m_read_data (m_read_data),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Grant and response monitors pop the scoreboard
    always @(negedge clk) begin
        if (rst_n && req_rdy != '0) begin
            if (exp_gnt.size() == 0) check("gnt_unexp", 32'(req_rdy), 32'd0);
            else check("gnt_order", 32'(req_rdy), 32'd1 << exp_gnt.pop_front());
        end
        if (rst_n && rsp_vld != '0) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexp", 32'(rsp_vld), 32'd0);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check("rsp_vld", 32'(rsp_vld), 32'd1 << e.id);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    task automatic set_cmd(input int id, input logic [11:0] c);
        cmds[id] = c;
        req_cmd[id*CmdW +: CmdW] = c;
    endtask

    task automatic push_rsp(input int id, input bit err, input logic [7:0] data);
        rsp_t e;
        e.id = id;
        e.err = err;
        e.data = data;
        exp_rsp.push_back(e);
    endtask

    task automatic wait_grant(input int id, output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (req_rdy[id]) break;
        end
        check("grant_seen", 32'(req_rdy[id]), 32'd1);
    endtask

    // Called at a negedge; m_cmd_vld normally already high on the grant cycle
    task automatic wait_mvld(input logic [11:0] c);
        for (int i = 0; i < 50; i++) begin
            if (m_cmd_vld) break;
            @(negedge clk);
        end
        check("m_cmd_vld", 32'(m_cmd_vld), 32'd1);
        check("m_cmd", 32'(m_cmd), 32'(c));
    endtask

    // Requires m_cmd_rdy=1 so the next posedge is the accept edge
    task automatic serve_write(input int pre, input int busy_cyc);
        @(posedge clk);
        repeat (pre) @(posedge clk);
        #1 m_cmd_rdy = 1'b0;
        repeat (busy_cyc) @(posedge clk);
        #1 m_cmd_rdy = 1'b1;
    endtask

    task automatic serve_read(input int busy_cyc, input logic [7:0] d);
        @(posedge clk);
        #1 m_cmd_rdy = 1'b0;
        repeat (busy_cyc) @(posedge clk);
        #1 m_read_vld = 1'b1;
        m_read_data = d;
        @(posedge clk);
        #1 m_read_vld = 1'b0;
        m_read_data = ~d;
        repeat (3) @(posedge clk);
        #1 m_cmd_rdy = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 6000; i++) begin
            if (exp_rsp.size() == 0 && exp_gnt.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check(tag, 32'(exp_rsp.size() + exp_gnt.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [11:0] c0;
        int errs;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({busy, m_cmd_vld, req_rdy, rsp_vld, rsp_err}), 32'd0);
        check("rst_data", 32'({m_cmd, rsp_data, grant_id}), 32'd0);
        rst_n = 1'b1;

        // 1: requester 0 write, busy window of 40 cycles
        @(posedge clk);
        #1;
        set_cmd(0, 12'h8A5);
        exp_gnt.push_back(0);
        push_rsp(0, 1'b0, 8'h00);
        req_vld = 4'b0001;
        wait_grant(0, n);
        check("rdy_latency", 32'(n), 32'd2);
        req_vld = '0;
        wait_mvld(12'h8A5);
        serve_write(2, 40);
        wait_drain("t1_drain");

        // 2: stray read-valid while idle is ignored, then requester 2 read
        m_read_vld = 1'b1;
        m_read_data = 8'hEE;
        repeat (2) @(negedge clk);
        m_read_vld = 1'b0;
        set_cmd(2, 12'h03C);
        exp_gnt.push_back(2);
        push_rsp(2, 1'b0, 8'h5A);
        req_vld = 4'b0100;
        wait_grant(2, n);
        req_vld = '0;
        wait_mvld(12'h03C);
        serve_read(5, 8'h5A);
        wait_drain("t2_drain");
        repeat (5) @(negedge clk);
        check("rsp_data_hold", 32'(rsp_data), 32'h5A);

        // 3: all requesters held valid from reset -> 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < NumReq; i++) set_cmd(i, {1'b1, 3'(i), 8'(i * 17 + 3)});
        for (int k = 0; k < 8; k++) begin
            exp_gnt.push_back(k % NumReq);
            push_rsp(k % NumReq, 1'b0, 8'h00);
        end
        req_vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_grant(k % NumReq, n);
            if (k == 7) req_vld = '0;
            check("grant_id", 32'(grant_id), 32'(k % NumReq));
            wait_mvld(cmds[k % NumReq]);
            serve_write(0, 2);
        end
        wait_drain("t3_drain");

        // 4: master never finishes -> timeout exactly Tmo cycles after accept
        set_cmd(1, 12'h855);
        exp_gnt.push_back(1);
        push_rsp(1, 1'b1, 8'h00);
        req_vld = 4'b0010;
        wait_grant(1, n);
        req_vld = '0;
        wait_mvld(12'h855);
        @(posedge clk);
        #1;
        set_cmd(2, 12'h0C3);
        exp_gnt.push_back(2);
        req_vld = 4'b0100;
        n = 0;
        while (n < Tmo + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_vld != '0) break;
        end
        check("tmo_cycles", 32'(n), 32'(Tmo));
        wait_grant(2, n);
        req_vld = '0;
        push_rsp(2, 1'b0, 8'hC3);
        wait_mvld(12'h0C3);
        serve_read(5, 8'hC3);
        wait_drain("t4_drain");

        // 4b: completion on the timeout cycle wins
        set_cmd(0, 12'h901);
        exp_gnt.push_back(0);
        push_rsp(0, 1'b0, 8'h00);
        req_vld = 4'b0001;
        wait_grant(0, n);
        req_vld = '0;
        wait_mvld(12'h901);
        @(posedge clk);
        #1 m_cmd_rdy = 1'b0;
        repeat (Tmo - 1) @(posedge clk);
        #1 m_cmd_rdy = 1'b1;
        wait_drain("t4b_drain");

        // 5: master not ready for 100 cycles in ISSUE -> command held, no timeout
        m_cmd_rdy = 1'b0;
        set_cmd(3, 12'h70F);
        exp_gnt.push_back(3);
        push_rsp(3, 1'b0, 8'hA6);
        req_vld = 4'b1000;
        wait_grant(3, n);
        req_vld = '0;
        wait_mvld(12'h70F);
        c0 = m_cmd;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (!m_cmd_vld || m_cmd !== c0 || rsp_vld != '0) errs++;
        end
        check("issue_hold", 32'(errs), 32'd0);
        m_cmd_rdy = 1'b1;
        serve_read(5, 8'hA6);
        wait_drain("t5_drain");

        // 6: reset during WAIT_DONE clears everything at once
        set_cmd(1, 12'h9C1);
        exp_gnt.push_back(1);
        req_vld = 4'b0010;
        wait_grant(1, n);
        req_vld = '0;
        wait_mvld(12'h9C1);
        @(posedge clk);
        #1 m_cmd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_wait_done", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'({busy, m_cmd_vld, req_rdy, rsp_vld, rsp_err}), 32'd0);
        check("mid_rst_data", 32'({m_cmd, rsp_data, grant_id}), 32'd0);
        m_cmd_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NumReq; i++) set_cmd(i, {1'b1, 3'(i), 8'h40 + 8'(i)});
        exp_gnt.push_back(0);
        push_rsp(0, 1'b0, 8'h00);
        req_vld = 4'hF;
        wait_grant(0, n);
        req_vld = '0;
        wait_mvld(cmds[0]);
        serve_write(0, 3);
        wait_drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
